// File: rtl/sata_crc_checker_if.sv
// rtl/sata_crc_checker_if.sv - descrambled dword input stream and stripped output stream of the CRC checker
interface sata_crc_checker_if;
    logic        s_axis_tvalid;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tabort;

    // master is the link-layer side feeding dwords in and taking frames out
    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tabort
    );

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast,
        output m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tabort
    );
endinterface

// File: rtl/sata_crc_checker.sv
// rtl/sata_crc_checker.sv - SATA receive frame CRC checker that strips the trailing CRC dword
module sata_crc_checker #(
    parameter bit          OPT_LOWPOWER = 1'b0,
    parameter int          LGMAXLEN     = 11,
    parameter logic [31:0] INITIAL_CRC  = 32'h52325032,
    parameter logic [31:0] POLYNOMIAL   = 32'h04C11DB7
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_cfg_crc_en,
    sata_crc_checker_if.slave axis
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    localparam logic [LGMAXLEN:0] MAXLEN = {1'b1, {LGMAXLEN{1'b0}}};

    logic [1:0]        state;
    logic [31:0]       crc;
    logic [31:0]       held;
    logic [LGMAXLEN:0] count;
    logic              en_r;
    logic [31:0]       next_crc;

    logic              m_valid;
    logic [31:0]       m_data;
    logic              m_last;
    logic              m_abort;

    function automatic logic [31:0] advance(input logic [31:0] c_in, input logic [31:0] d);
        logic [31:0] c;
        c = c_in;
        for (int k = 0; k < 32; k++) begin
            if (c[31] ^ d[31-k])
                c = {c[30:0], 1'b0} ^ POLYNOMIAL;
            else
                c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    assign next_crc = advance(crc, axis.s_axis_tdata);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state   <= S_IDLE;
            crc     <= INITIAL_CRC;
            held    <= 32'h0;
            count   <= '0;
            en_r    <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= 32'h0;
            m_last  <= 1'b0;
            m_abort <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_abort <= 1'b0;
            if (OPT_LOWPOWER)
                m_data <= 32'h0;

            if (axis.s_axis_tvalid) begin
                case (state)
                    S_IDLE: begin
                        if (axis.s_axis_tlast) begin
                            // a CRC with no data in front of it is an empty frame
                            m_valid <= 1'b1;
                            m_data  <= 32'h0;
                            m_last  <= 1'b1;
                            m_abort <= 1'b1;
                            crc     <= INITIAL_CRC;
                        end else begin
                            held  <= axis.s_axis_tdata;
                            crc   <= next_crc;
                            count <= {{LGMAXLEN{1'b0}}, 1'b1};
                            en_r  <= i_cfg_crc_en;
                            state <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        m_valid <= 1'b1;
                        m_data  <= held;
                        if (axis.s_axis_tlast) begin
                            m_last  <= 1'b1;
                            m_abort <= en_r && (crc != axis.s_axis_tdata);
                            crc     <= INITIAL_CRC;
                            state   <= S_IDLE;
                        end else if (count == MAXLEN) begin
                            m_last  <= 1'b1;
                            m_abort <= 1'b1;
                            state   <= S_DROP;
                        end else begin
                            held  <= axis.s_axis_tdata;
                            crc   <= next_crc;
                            count <= count + 1'b1;
                        end
                    end
                    S_DROP: begin
                        if (axis.s_axis_tlast) begin
                            crc   <= INITIAL_CRC;
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        crc   <= INITIAL_CRC;
                    end
                endcase
            end
        end
    end

    assign axis.m_axis_tvalid = m_valid;
    assign axis.m_axis_tdata  = m_data;
    assign axis.m_axis_tlast  = m_last;
    assign axis.m_axis_tabort = m_abort;
endmodule

// File: tb/tb_sata_crc_checker.sv
// tb/tb_sata_crc_checker.sv - randomized frame-level bench for sata_crc_checker (full-length and LGMAXLEN=2 instances)
module tb_sata_crc_checker;
    localparam logic [31:0] INIT = 32'h52325032;
    localparam logic [31:0] POLY = 32'h04C11DB7;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] data;
        logic        last;
        logic        abort;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_en = 1'b0;
    logic        s_tvalid = 1'b0;
    logic [31:0] s_tdata = 32'h0;
    logic        s_tlast = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          idle_viol = 0;
    bit          mon_en = 1'b0;

    logic [31:0] fw[$];
    int          bc[$];
    beat_t       got_q[2][$];
    beat_t       exp_q[2][$];

    sata_crc_checker_if bus_a();
    sata_crc_checker_if bus_b();

    assign bus_a.s_axis_tvalid = s_tvalid;
    assign bus_a.s_axis_tdata  = s_tdata;
    assign bus_a.s_axis_tlast  = s_tlast;
    assign bus_b.s_axis_tvalid = s_tvalid;
    assign bus_b.s_axis_tdata  = s_tdata;
    assign bus_b.s_axis_tlast  = s_tlast;

    sata_crc_checker dut_a (
        .i_clk(clk), .i_reset(rst_n), .i_cfg_crc_en(cfg_en), .axis(bus_a)
    );

    sata_crc_checker #(.OPT_LOWPOWER(1'b1), .LGMAXLEN(2)) dut_b (
        .i_clk(clk), .i_reset(rst_n), .i_cfg_crc_en(cfg_en), .axis(bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_a.m_axis_tvalid === 1'b1)
            got_q[0].push_back({32'(cyc), bus_a.m_axis_tdata, bus_a.m_axis_tlast, bus_a.m_axis_tabort});
        if (bus_b.m_axis_tvalid === 1'b1)
            got_q[1].push_back({32'(cyc), bus_b.m_axis_tdata, bus_b.m_axis_tlast, bus_b.m_axis_tabort});
        if (mon_en && bus_a.m_axis_tvalid !== 1'b1 && {bus_a.m_axis_tlast, bus_a.m_axis_tabort} !== 2'b00)
            idle_viol++;
        if (mon_en && bus_b.m_axis_tvalid !== 1'b1 &&
            {bus_b.m_axis_tdata, bus_b.m_axis_tlast, bus_b.m_axis_tabort} !== 34'h0)
            idle_viol++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] frame_crc();
        logic [31:0] c = INIT;
        foreach (fw[i])
            for (int k = 0; k < 32; k++)
                c = {c[30:0], 1'b0} ^ ((c[31] ^ fw[i][31-k]) ? POLY : 32'h0);
        return c;
    endfunction

    task automatic idle_cycle();
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tdata  = $urandom;
        s_tlast  = 1'($urandom);
        cfg_en   = 1'($urandom);
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic l, input logic en);
        @(posedge clk); #1;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        cfg_en   = en;
    endtask

    task automatic settle();
        repeat (5) idle_cycle();
        @(negedge clk);
    endtask

    task automatic clear_queues();
        for (int d = 0; d < 2; d++) begin
            got_q[d].delete();
            exp_q[d].delete();
        end
    endtask

    // Drives fw (plus the CRC beat when has_crc) and appends the frame-level expectation for both instances.
    task automatic send_frame(input logic [31:0] crcw, input bit has_crc, input int gap_max, input bit en);
        int    n  = fw.size();
        int    nb = has_crc ? n + 1 : n;
        beat_t e;
        bc.delete();
        for (int b = 0; b < nb; b++) begin
            int g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) idle_cycle();
            drive_beat((b < n) ? fw[b] : crcw, b == n, (b == 0) ? en : 1'($urandom));
            bc.push_back(cyc + 1);
        end
        for (int d = 0; d < 2; d++) begin
            int ml   = (d == 1) ? 4 : 2048;
            bit over = (n > ml);
            int m    = over ? ml : n;
            if (n == 0 && has_crc) begin
                e.cyc = 32'(bc[0]); e.data = 32'h0; e.last = 1'b1; e.abort = 1'b1;
                exp_q[d].push_back(e);
            end
            for (int i = 0; i < m; i++) begin
                if (i + 1 < nb) begin
                    e.cyc  = 32'(bc[i+1]);
                    e.data = fw[i];
                    e.last = over ? (i == m - 1) : (has_crc && i == n - 1);
                    e.abort = over ? e.last : (e.last && en && (frame_crc() != crcw));
                    exp_q[d].push_back(e);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) idle_cycle();
        @(negedge clk);
        n_cmp++;
        if ({bus_a.m_axis_tvalid, bus_a.m_axis_tdata, bus_a.m_axis_tlast, bus_a.m_axis_tabort} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_a: got v=%b d=%h l=%b a=%b, expected all 0", bus_a.m_axis_tvalid,
                     bus_a.m_axis_tdata, bus_a.m_axis_tlast, bus_a.m_axis_tabort);
        end
        n_cmp++;
        if ({bus_b.m_axis_tvalid, bus_b.m_axis_tdata, bus_b.m_axis_tlast, bus_b.m_axis_tabort} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_b: got v=%b d=%h l=%b a=%b, expected all 0", bus_b.m_axis_tvalid,
                     bus_b.m_axis_tdata, bus_b.m_axis_tlast, bus_b.m_axis_tabort);
        end
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        clear_queues();
    endtask

    task automatic test_good_frame();
        logic [31:0] c;
        clear_queues();
        fw = '{32'h11111111, 32'h22222222, 32'h33333333};
        c = frame_crc();
        send_frame(c, 1'b1, 0, 1'b1);
        settle();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (got_q[d].size() !== exp_q[d].size()) begin
                n_fail++;
                $display("FAIL good_frame dut%0d beats: got %0d expected %0d", d, got_q[d].size(), exp_q[d].size());
            end
            for (int i = 0; i < got_q[d].size() && i < exp_q[d].size(); i++) begin
                n_cmp++;
                if (got_q[d][i] !== exp_q[d][i]) begin
                    n_fail++;
                    $display("FAIL good_frame dut%0d beat%0d: got %h expected %h (cyc,data,last,abort)", d, i, got_q[d][i], exp_q[d][i]);
                end
            end
        end
    endtask

    task automatic test_crc_error();
        logic [31:0] c;
        clear_queues();
        fw = '{32'h11111111, 32'h22222222, 32'h33333333};
        c = frame_crc();
        fw[1] = fw[1] ^ 32'h1;
        send_frame(c, 1'b1, 0, 1'b1);
        send_frame(c, 1'b1, 0, 1'b0);
        settle();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (got_q[d].size() !== exp_q[d].size()) begin
                n_fail++;
                $display("FAIL crc_error dut%0d beats: got %0d expected %0d", d, got_q[d].size(), exp_q[d].size());
            end
            for (int i = 0; i < got_q[d].size() && i < exp_q[d].size(); i++) begin
                n_cmp++;
                if (got_q[d][i] !== exp_q[d][i]) begin
                    n_fail++;
                    $display("FAIL crc_error dut%0d beat%0d: got %h expected %h (cyc,data,last,abort)", d, i, got_q[d][i], exp_q[d][i]);
                end
            end
        end
    endtask

    task automatic test_empty_frame();
        logic [31:0] c;
        clear_queues();
        fw.delete();
        send_frame(32'hDEADBEEF, 1'b1, 0, 1'b1);
        fw = '{$urandom, $urandom};
        c = frame_crc();
        send_frame(c, 1'b1, 0, 1'b1);
        settle();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (got_q[d].size() !== exp_q[d].size()) begin
                n_fail++;
                $display("FAIL empty_frame dut%0d beats: got %0d expected %0d", d, got_q[d].size(), exp_q[d].size());
            end
            for (int i = 0; i < got_q[d].size() && i < exp_q[d].size(); i++) begin
                n_cmp++;
                if (got_q[d][i] !== exp_q[d][i]) begin
                    n_fail++;
                    $display("FAIL empty_frame dut%0d beat%0d: got %h expected %h (cyc,data,last,abort)", d, i, got_q[d][i], exp_q[d][i]);
                end
            end
        end
    endtask

    task automatic test_overlength();
        logic [31:0] c;
        clear_queues();
        fw = '{$urandom, $urandom, $urandom, $urandom, $urandom};
        c = frame_crc();
        send_frame(c, 1'b1, 0, 1'b1);
        fw = '{$urandom, $urandom, $urandom};
        c = frame_crc();
        send_frame(c, 1'b1, 0, 1'b1);
        settle();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (got_q[d].size() !== exp_q[d].size()) begin
                n_fail++;
                $display("FAIL overlength dut%0d beats: got %0d expected %0d", d, got_q[d].size(), exp_q[d].size());
            end
            for (int i = 0; i < got_q[d].size() && i < exp_q[d].size(); i++) begin
                n_cmp++;
                if (got_q[d][i] !== exp_q[d][i]) begin
                    n_fail++;
                    $display("FAIL overlength dut%0d beat%0d: got %h expected %h (cyc,data,last,abort)", d, i, got_q[d][i], exp_q[d][i]);
                end
            end
        end
    endtask

    task automatic test_gaps();
        logic [31:0] c;
        clear_queues();
        repeat (3) begin
            for (int f = 0; f < 2; f++) begin
                fw.delete();
                repeat ($urandom_range(4, 1)) fw.push_back($urandom);
                c = frame_crc();
                send_frame(c, 1'b1, (f == 0) ? 5 : 0, 1'b1);
            end
        end
        settle();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (got_q[d].size() !== exp_q[d].size()) begin
                n_fail++;
                $display("FAIL gaps dut%0d beats: got %0d expected %0d", d, got_q[d].size(), exp_q[d].size());
            end
            for (int i = 0; i < got_q[d].size() && i < exp_q[d].size(); i++) begin
                n_cmp++;
                if (got_q[d][i] !== exp_q[d][i]) begin
                    n_fail++;
                    $display("FAIL gaps dut%0d beat%0d: got %h expected %h (cyc,data,last,abort)", d, i, got_q[d][i], exp_q[d][i]);
                end
            end
        end
    endtask

    task automatic test_midframe_reset();
        logic [31:0] c;
        clear_queues();
        fw = '{$urandom, $urandom};
        send_frame(32'h0, 1'b0, 0, 1'b1);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus_a.m_axis_tvalid, bus_b.m_axis_tvalid, bus_b.m_axis_tdata} !== 34'h0) begin
            n_fail++;
            $display("FAIL midframe_reset outputs: got va=%b vb=%b db=%h expected 0", bus_a.m_axis_tvalid,
                     bus_b.m_axis_tvalid, bus_b.m_axis_tdata);
        end
        fw = '{$urandom};
        c = frame_crc();
        send_frame(c, 1'b1, 0, 1'b1);
        settle();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (got_q[d].size() !== exp_q[d].size()) begin
                n_fail++;
                $display("FAIL midframe_reset dut%0d beats: got %0d expected %0d", d, got_q[d].size(), exp_q[d].size());
            end
            for (int i = 0; i < got_q[d].size() && i < exp_q[d].size(); i++) begin
                n_cmp++;
                if (got_q[d][i] !== exp_q[d][i]) begin
                    n_fail++;
                    $display("FAIL midframe_reset dut%0d beat%0d: got %h expected %h (cyc,data,last,abort)", d, i, got_q[d][i], exp_q[d][i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] c;
        clear_queues();
        repeat (10) begin
            fw.delete();
            repeat ($urandom_range(6, 0)) fw.push_back($urandom);
            c = frame_crc();
            if ($urandom_range(1, 0) == 1)
                c = c ^ (32'h1 << $urandom_range(31, 0));
            send_frame(c, 1'b1, 0, 1'($urandom));
        end
        settle();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (got_q[d].size() !== exp_q[d].size()) begin
                n_fail++;
                $display("FAIL back_to_back dut%0d beats: got %0d expected %0d", d, got_q[d].size(), exp_q[d].size());
            end
            for (int i = 0; i < got_q[d].size() && i < exp_q[d].size(); i++) begin
                n_cmp++;
                if (got_q[d][i] !== exp_q[d][i]) begin
                    n_fail++;
                    $display("FAIL back_to_back dut%0d beat%0d: got %h expected %h (cyc,data,last,abort)", d, i, got_q[d][i], exp_q[d][i]);
                end
            end
        end
    endtask

    task automatic test_idle_outputs();
        n_cmp++;
        if (idle_viol !== 0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %0d cycles with nonzero last/abort/lowpower data while invalid, expected 0", idle_viol);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_crc_error();
        test_empty_frame();
        test_overlength();
        test_gaps();
        test_midframe_reset();
        test_back_to_back();
        test_idle_outputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
